// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package hazard_ctrl_pkg;
    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;
endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stall cycles (saturating) and latches a sticky error
// once a stall outlives MAX_STALL edges.
module stall_watchdog
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall,
    output logic o_stall_err
);
    localparam int unsigned RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);

    logic [RUN_W-1:0] r_run;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= '0;
            r_err <= NO;
        end else if (i_stall) begin
            // The edge that would take the streak past MAX_STALL trips the flag
            if (r_run >= RUN_LIM)
                r_err <= YES;
            if (r_run != RUN_SAT)
                r_run <= r_run + RUN_W'(1);
        end else begin
            r_run <= '0;
        end
    end

    assign o_stall_err = r_err;
endmodule

// File: rtl/hazard_ctrl.sv
// PC and IF/ID owner: freezes on stall requests, redirects and flushes on
// resolved branches, and keeps stall/flush statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LoadStall,
    input  logic             LoadUse,
    input  logic             Redirect,
    input  logic [31:0]      RedirTarget,
    input  logic [31:0]      IMemInst,
    output logic [31:0]      pc,
    output logic [31:0]      IF_ID_pc,
    output logic [31:0]      IF_ID_inst,
    output logic             IF_ID_valid,
    output logic             ID_EX_bubble,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic             StallErr
);
    logic [31:0]      r_pc;
    logic [31:0]      r_if_id_pc;
    logic [31:0]      r_if_id_inst;
    logic             r_if_id_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    state_t           r_state;
    state_t           w_next_state;
    logic             w_stall;
    logic             w_redir;
    logic             w_stall_err;

    // Branch operands are stale while stalled, and a bubble never redirects
    assign w_stall = LoadStall | LoadUse;
    assign w_redir = Redirect & r_if_id_valid & ~w_stall;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = RUN;
        if (w_stall)
            w_next_state = STALL;
        else if (w_redir)
            w_next_state = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= '0;
            r_if_id_inst  <= NOP_INST;
            r_if_id_valid <= NO;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else if (w_stall) begin
            r_stall_cnt   <= r_stall_cnt + 1'b1;
        end else if (w_redir) begin
            r_pc          <= RedirTarget;
            r_if_id_pc    <= '0;
            r_if_id_inst  <= NOP_INST;
            r_if_id_valid <= NO;
            r_flush_cnt   <= r_flush_cnt + 1'b1;
        end else begin
            r_pc          <= r_pc + 32'd4;
            r_if_id_pc    <= r_pc;
            r_if_id_inst  <= IMemInst;
            r_if_id_valid <= YES;
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (w_stall),
        .o_stall_err (w_stall_err)
    );

    assign pc           = r_pc;
    assign IF_ID_pc     = r_if_id_pc;
    assign IF_ID_inst   = r_if_id_inst;
    assign IF_ID_valid  = r_if_id_valid;
    assign ID_EX_bubble = w_stall;
    assign State        = r_state;
    assign StallCnt     = r_stall_cnt;
    assign FlushCnt     = r_flush_cnt;
    assign StallErr     = w_stall_err;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against an in-bench
// behavioural model of the fetch/IF-ID pipeline.
module tb_hazard_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          MAXS   = 4;

    logic        clk = 1'b0;
    logic        rst, LoadStall, LoadUse, Redirect;
    logic [31:0] RedirTarget, IMemInst;
    logic [31:0] pc, IF_ID_pc, IF_ID_inst, StallCnt, FlushCnt;
    logic        IF_ID_valid, ID_EX_bubble, StallErr;
    logic [1:0]  State;

    hazard_ctrl #(
        .RESET_PC  (RST_PC),
        .MAX_STALL (MAXS),
        .CNT_W     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .LoadStall    (LoadStall),
        .LoadUse      (LoadUse),
        .Redirect     (Redirect),
        .RedirTarget  (RedirTarget),
        .IMemInst     (IMemInst),
        .pc           (pc),
        .IF_ID_pc     (IF_ID_pc),
        .IF_ID_inst   (IF_ID_inst),
        .IF_ID_valid  (IF_ID_valid),
        .ID_EX_bubble (ID_EX_bubble),
        .State        (State),
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt),
        .StallErr     (StallErr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Behavioural model: what each output must hold after the latest edge
    logic [31:0] m_pc, m_ifpc, m_ifinst, m_stallcnt, m_flushcnt;
    logic        m_valid, m_err;
    int          m_state;
    int          m_streak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        if (rst) begin
            m_pc = RST_PC; m_ifpc = 0; m_ifinst = 32'h13; m_valid = 0;
            m_state = 0; m_stallcnt = 0; m_flushcnt = 0; m_err = 0; m_streak = 0;
        end else if (LoadStall || LoadUse) begin
            m_stallcnt = m_stallcnt + 1;
            m_streak   = m_streak + 1;
            if (m_streak > MAXS) m_err = 1;
            m_state = 1;
        end else if (Redirect && m_valid) begin
            m_pc = RedirTarget; m_ifpc = 0; m_ifinst = 32'h13; m_valid = 0;
            m_flushcnt = m_flushcnt + 1;
            m_streak = 0; m_state = 2;
        end else begin
            m_ifpc = m_pc; m_ifinst = IMemInst; m_valid = 1;
            m_pc = m_pc + 32'd4;
            m_streak = 0; m_state = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc", pc, m_pc);
            chk("IF_ID_pc", IF_ID_pc, m_ifpc);
            chk("IF_ID_inst", IF_ID_inst, m_ifinst);
            chk("IF_ID_valid", 32'(IF_ID_valid), 32'(m_valid));
            chk("ID_EX_bubble", 32'(ID_EX_bubble), 32'(LoadStall | LoadUse));
            chk("State", 32'(State), 32'(m_state));
            chk("StallCnt", StallCnt, m_stallcnt);
            chk("FlushCnt", FlushCnt, m_flushcnt);
            chk("StallErr", 32'(StallErr), 32'(m_err));
        end
    end

    task automatic drive(input logic r, input logic ls, input logic lu, input logic rd,
                         input logic [31:0] tgt, input logic [31:0] inst);
        rst = r; LoadStall = ls; LoadUse = lu; Redirect = rd;
        RedirTarget = tgt; IMemInst = inst;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic step(input logic r, input logic ls, input logic lu, input logic rd,
                        input logic [31:0] tgt, input logic [31:0] inst);
        drive(r, ls, lu, rd, tgt, inst);
        tick();
    endtask

    initial begin
        int burst;
        logic ls, lu;
        drive(1, 0, 0, 0, 0, 0);
        #1;
        tick();
        tick();
        chk_on = 1'b1;

        chk("rst pc", pc, 32'h100);
        chk("rst IF_ID_inst", IF_ID_inst, 32'h13);
        chk("rst IF_ID_valid", 32'(IF_ID_valid), 0);
        chk("rst State", 32'(State), 0);
        chk("rst StallCnt", StallCnt, 0);
        chk("rst StallErr", 32'(StallErr), 0);

        step(0, 0, 0, 0, 0, 32'hA);
        chk("free pc1", pc, 32'h104);
        step(0, 0, 0, 0, 0, 32'hB);
        step(0, 0, 0, 0, 0, 32'hC);
        chk("free pc3", pc, 32'h10C);
        chk("free inst", IF_ID_inst, 32'hC);
        chk("free ifpc", IF_ID_pc, 32'h108);
        chk("free valid", 32'(IF_ID_valid), 1);

        drive(0, 1, 0, 0, 0, 32'hEE);
        #1 chk("stall bubble", 32'(ID_EX_bubble), 1);
        tick();
        chk("stall pc1", pc, 32'h10C);
        chk("stall State", 32'(State), 1);
        step(0, 1, 0, 0, 0, 32'hEE);
        chk("stall pc2", pc, 32'h10C);
        chk("stall inst", IF_ID_inst, 32'hC);
        chk("stall cnt", StallCnt, 2);
        step(0, 0, 0, 0, 0, 32'hD);
        chk("release State", 32'(State), 0);
        chk("release pc", pc, 32'h110);

        step(0, 0, 0, 1, 32'h400, 32'hEE);
        chk("redir pc", pc, 32'h400);
        chk("redir inst", IF_ID_inst, 32'h13);
        chk("redir valid", 32'(IF_ID_valid), 0);
        chk("redir flush", FlushCnt, 1);
        chk("redir State", 32'(State), 2);
        step(0, 0, 0, 1, 32'h800, 32'hD0);
        chk("redir-invalid pc", pc, 32'h404);
        chk("after flush ifpc", IF_ID_pc, 32'h400);
        chk("after flush State", 32'(State), 0);

        drive(0, 0, 1, 1, 32'h600, 32'hEE);
        #1 chk("lu+redir bubble", 32'(ID_EX_bubble), 1);
        tick();
        chk("lu+redir pc", pc, 32'h404);
        step(0, 0, 0, 1, 32'h600, 32'hEE);
        chk("re-presented pc", pc, 32'h600);
        chk("re-presented State", 32'(State), 2);

        step(0, 0, 0, 0, 0, 32'h1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 32'h2);
        chk("wd 4 edges", 32'(StallErr), 0);
        step(0, 1, 0, 0, 0, 32'h2);
        chk("wd 5 edges", 32'(StallErr), 1);
        step(0, 0, 0, 0, 0, 32'h3);
        chk("wd sticky", 32'(StallErr), 1);
        step(1, 0, 0, 0, 0, 32'h3);
        chk("wd rst err", 32'(StallErr), 0);
        chk("wd rst stallcnt", StallCnt, 0);
        chk("wd rst flushcnt", FlushCnt, 0);

        step(0, 0, 0, 0, 0, 32'h4);
        step(0, 0, 0, 1, 32'hFFFF_FFF8, 32'h5);
        step(0, 0, 0, 0, 0, 32'h6);
        chk("wrap pre", pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 32'h7);
        chk("wrap pc", pc, 32'h0);
        chk("wrap ifpc", IF_ID_pc, 32'hFFFF_FFFC);

        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 7);
            ls = (burst > 0) || ($urandom_range(0, 5) == 0);
            lu = ($urandom_range(0, 7) == 0);
            if (burst > 0) burst--;
            step($urandom_range(0, 99) == 0, ls, lu, $urandom_range(0, 3) == 0,
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
